// File: rtl/ssm_tile_feeder.sv
// ssm_tile_feeder: two-slot ping-pong group buffer streaming each N_TOTAL-lane group as N_TILE-lane tiles at II=1
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   flush_i                        synchronous clear of all buffered groups (slot data kept)
//   grp_valid_i / grp_ready_o      group handshake; ready means slot wr_ptr is free
//   dt_i, dA_i, x_i, D_i           group scalars
//   B_vec_i, C_vec_i, hprev_vec_i  N_TOTAL-lane group vectors, lane n at [n*DW +: DW]
//   tile_valid_o / tile_ready_i    tile handshake
//   tile_idx_o, tile_first_o, tile_last_o   tile position within the group
//   dt_o, dA_o, x_o, D_o           scalars of the group being streamed
//   B_tile_o, C_tile_o, hprev_tile_o        current N_TILE-lane slice of the stored vectors
//   grp_done_o, grp_cnt_o          registered end-of-group pulse and wrapping group count
module ssm_tile_feeder #(
   parameter int DW      = 16,
   parameter int N_TILE  = 16,
   parameter int N_TOTAL = 128,
   parameter int TW      = $clog2(N_TOTAL / N_TILE)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush_i,
   input  logic                   grp_valid_i,
   output logic                   grp_ready_o,
   input  logic [DW-1:0]          dt_i,
   input  logic [DW-1:0]          dA_i,
   input  logic [DW-1:0]          x_i,
   input  logic [DW-1:0]          D_i,
   input  logic [N_TOTAL*DW-1:0]  B_vec_i,
   input  logic [N_TOTAL*DW-1:0]  C_vec_i,
   input  logic [N_TOTAL*DW-1:0]  hprev_vec_i,
   output logic                   tile_valid_o,
   input  logic                   tile_ready_i,
   output logic [TW-1:0]          tile_idx_o,
   output logic                   tile_first_o,
   output logic                   tile_last_o,
   output logic [DW-1:0]          dt_o,
   output logic [DW-1:0]          dA_o,
   output logic [DW-1:0]          x_o,
   output logic [DW-1:0]          D_o,
   output logic [N_TILE*DW-1:0]   B_tile_o,
   output logic [N_TILE*DW-1:0]   C_tile_o,
   output logic [N_TILE*DW-1:0]   hprev_tile_o,
   output logic                   grp_done_o,
   output logic [15:0]            grp_cnt_o
);
   localparam int VW = N_TOTAL * DW;
   localparam int TLW = N_TILE * DW;
   localparam logic [TW-1:0] LAST = TW'(N_TOTAL / N_TILE - 1);
   logic [1:0][DW-1:0] dt_s, da_s, x_s, d_s;
   logic [1:0][VW-1:0] b_s, c_s, h_s;
   logic [1:0]         full;
   logic               wr_ptr, rd_ptr;
   logic [TW-1:0]      tcnt;
   logic               grp_done;
   logic [15:0]        grp_cnt;
   logic               acc, xfer, xfer_last;
   // ready looks only at registered state, so a slot freed this cycle is
   // offered next cycle; accept and drain therefore never hit the same slot
   assign grp_ready_o  = !full[wr_ptr];
   assign tile_valid_o = full[rd_ptr];
   assign acc          = grp_valid_i && grp_ready_o;
   assign xfer         = tile_valid_o && tile_ready_i;
   assign xfer_last    = xfer && tcnt == LAST;
   assign tile_idx_o   = tcnt;
   assign tile_first_o = tile_valid_o && tcnt == '0;
   assign tile_last_o  = tile_valid_o && tcnt == LAST;
   assign dt_o         = dt_s[rd_ptr];
   assign dA_o         = da_s[rd_ptr];
   assign x_o          = x_s[rd_ptr];
   assign D_o          = d_s[rd_ptr];
   assign B_tile_o     = b_s[rd_ptr][int'(tcnt) * TLW +: TLW];
   assign C_tile_o     = c_s[rd_ptr][int'(tcnt) * TLW +: TLW];
   assign hprev_tile_o = h_s[rd_ptr][int'(tcnt) * TLW +: TLW];
   assign grp_done_o   = grp_done;
   assign grp_cnt_o    = grp_cnt;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dt_s     <= '0;
         da_s     <= '0;
         x_s      <= '0;
         d_s      <= '0;
         b_s      <= '0;
         c_s      <= '0;
         h_s      <= '0;
         full     <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         tcnt     <= '0;
         grp_done <= 1'b0;
         grp_cnt  <= '0;
      end else if (flush_i) begin
         full     <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         tcnt     <= '0;
         grp_done <= 1'b0;
      end else begin
         grp_done <= xfer_last;
         grp_cnt  <= grp_cnt + 16'(xfer_last);
         if (acc) begin
            dt_s[wr_ptr] <= dt_i;
            da_s[wr_ptr] <= dA_i;
            x_s[wr_ptr]  <= x_i;
            d_s[wr_ptr]  <= D_i;
            b_s[wr_ptr]  <= B_vec_i;
            c_s[wr_ptr]  <= C_vec_i;
            h_s[wr_ptr]  <= hprev_vec_i;
            full[wr_ptr] <= 1'b1;
            wr_ptr       <= !wr_ptr;
         end
         if (xfer) tcnt <= xfer_last ? '0 : tcnt + 1'b1;
         if (xfer_last) begin
            full[rd_ptr] <= 1'b0;
            rd_ptr       <= !rd_ptr;
         end
      end
   end
endmodule

// File: tb/tb_ssm_tile_feeder.sv
// tb_ssm_tile_feeder: scoreboard bench for ssm_tile_feeder
module tb_ssm_tile_feeder;
   localparam int DW = 16;
   localparam int NT = 16;
   localparam int NG = 128;
   localparam int TW = 3;
   typedef struct {int g; int idx;} tile_t;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic flush_i = 1'b0, grp_valid_i = 1'b0, grp_ready_o;
   logic [DW-1:0] dt_i = '0, dA_i = '0, x_i = '0, D_i = '0;
   logic [NG*DW-1:0] B_vec_i = '0, C_vec_i = '0, hprev_vec_i = '0;
   logic tile_valid_o, tile_ready_i = 1'b0, tile_first_o, tile_last_o, grp_done_o;
   logic [TW-1:0] tile_idx_o;
   logic [DW-1:0] dt_o, dA_o, x_o, D_o;
   logic [NT*DW-1:0] B_tile_o, C_tile_o, hprev_tile_o;
   logic [15:0] grp_cnt_o;
   tile_t q[$];
   int errors = 0, checks = 0, cur_g = 1, vrun = 0, vmax = 0;
   logic acc = 1'b0, done_pend = 1'b0, done_exp = 1'b0, stall_prev = 1'b0;
   logic [15:0] cnt_exp = '0;
   logic [255:0] b_prev = '0;
   logic [TW-1:0] idx_prev = '0;

   always #5 clk = ~clk;

   ssm_tile_feeder #(.DW(DW), .N_TILE(NT), .N_TOTAL(NG), .TW(TW)) dut (
      .clk(clk), .rstn(rstn), .flush_i(flush_i), .grp_valid_i(grp_valid_i), .grp_ready_o(grp_ready_o),
      .dt_i(dt_i), .dA_i(dA_i), .x_i(x_i), .D_i(D_i),
      .B_vec_i(B_vec_i), .C_vec_i(C_vec_i), .hprev_vec_i(hprev_vec_i),
      .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i), .tile_idx_o(tile_idx_o),
      .tile_first_o(tile_first_o), .tile_last_o(tile_last_o),
      .dt_o(dt_o), .dA_o(dA_o), .x_o(x_o), .D_o(D_o),
      .B_tile_o(B_tile_o), .C_tile_o(C_tile_o), .hprev_tile_o(hprev_tile_o),
      .grp_done_o(grp_done_o), .grp_cnt_o(grp_cnt_o)
   );

   function automatic logic [15:0] lane(input int g, input int v, input int n);
      return 16'((g << 12) + v * 32'h400 + n);
   endfunction

   function automatic logic [255:0] tile(input int g, input int v, input int idx);
      logic [255:0] t;
      for (int l = 0; l < NT; l++) t[l*16 +: 16] = lane(g, v, idx * NT + l);
      return t;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_grp(input int g);
      dt_i = 16'(32'h0100 + g);
      dA_i = 16'(32'h0200 + g);
      x_i  = 16'(32'h0300 + g);
      D_i  = 16'(32'h0400 + g);
      for (int n = 0; n < NG; n++) begin
         B_vec_i[n*16 +: 16]     = lane(g, 0, n);
         C_vec_i[n*16 +: 16]     = lane(g, 1, n);
         hprev_vec_i[n*16 +: 16] = lane(g, 2, n);
      end
      grp_valid_i = 1'b1;
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_ready"}, 256'(grp_ready_o), 256'(1));
      chk({tag, "_valid"}, 256'(tile_valid_o), 256'(0));
      chk({tag, "_idx"}, 256'(tile_idx_o), 256'(0));
      chk({tag, "_first"}, 256'(tile_first_o), 256'(0));
      chk({tag, "_last"}, 256'(tile_last_o), 256'(0));
      chk({tag, "_done"}, 256'(grp_done_o), 256'(0));
      chk({tag, "_cnt"}, 256'(grp_cnt_o), 256'(0));
      chk({tag, "_scalars"}, 256'({dt_o, dA_o, x_o, D_o}), 256'(0));
      chk({tag, "_b"}, B_tile_o, 256'(0));
      chk({tag, "_c"}, C_tile_o, 256'(0));
      chk({tag, "_h"}, hprev_tile_o, 256'(0));
   endtask

   // one clock cycle: compare at the falling edge, update the model, return just after the rising edge
   task automatic tick();
      tile_t e, n;
      int occ;
      @(negedge clk);
      acc = 1'b0;
      if (stall_prev) begin
         chk("stall_b", B_tile_o, b_prev);
         chk("stall_idx", 256'(tile_idx_o), 256'(idx_prev));
      end
      done_exp = done_pend;
      cnt_exp  = cnt_exp + 16'(done_exp);
      chk("grp_done", 256'(grp_done_o), 256'(done_exp));
      chk("grp_cnt", 256'(grp_cnt_o), 256'(cnt_exp));
      occ = (q.size() + 7) / 8;
      chk("grp_ready", 256'(grp_ready_o), 256'(occ < 2));
      chk("tile_valid", 256'(tile_valid_o), 256'(q.size() > 0));
      vrun = tile_valid_o ? vrun + 1 : 0;
      if (vrun > vmax) vmax = vrun;
      stall_prev = tile_valid_o && !tile_ready_i && !flush_i;
      b_prev = B_tile_o;
      idx_prev = tile_idx_o;
      done_pend = 1'b0;
      if (flush_i) q.delete();
      else begin
         if (tile_valid_o && tile_ready_i && q.size() > 0) begin
            e = q.pop_front();
            chk("idx", 256'(tile_idx_o), 256'(e.idx));
            chk("first", 256'(tile_first_o), 256'(e.idx == 0));
            chk("last", 256'(tile_last_o), 256'(e.idx == 7));
            chk("scalars", 256'({dt_o, dA_o, x_o, D_o}),
                256'({16'(32'h100 + e.g), 16'(32'h200 + e.g), 16'(32'h300 + e.g), 16'(32'h400 + e.g)}));
            chk("b_tile", B_tile_o, tile(e.g, 0, e.idx));
            chk("c_tile", C_tile_o, tile(e.g, 1, e.idx));
            chk("h_tile", hprev_tile_o, tile(e.g, 2, e.idx));
            done_pend = (e.idx == 7);
         end
         if (grp_valid_i && grp_ready_o) begin
            acc = 1'b1;
            for (int i = 0; i < 8; i++) begin
               n.g = cur_g;
               n.idx = i;
               q.push_back(n);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int ngrp, input bit rnd);
      int sent = 0;
      int cyc = 0;
      while ((sent < ngrp || q.size() > 0 || done_pend) && cyc < 600) begin
         if (sent < ngrp) drive_grp(cur_g);
         else grp_valid_i = 1'b0;
         tile_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         if (acc) begin
            sent++;
            cur_g++;
         end
         cyc++;
      end
      grp_valid_i = 1'b0;
      chk("run_bound", 256'(cyc < 600), 256'(1));
   endtask

   initial begin
      #12;
      reset_chk("reset");
      @(negedge clk) rstn = 1'b1;
      @(posedge clk);
      #1;
      run(1, 1'b0);
      chk("cnt_after_one", 256'(grp_cnt_o), 256'(1));
      vrun = 0;
      vmax = 0;
      run(3, 1'b0);
      chk("gapfree_run", 256'(vmax), 256'(24));
      run(3, 1'b1);
      tile_ready_i = 1'b0;
      drive_grp(cur_g);
      tick();
      cur_g++;
      drive_grp(cur_g);
      tick();
      cur_g++;
      drive_grp(cur_g);
      tile_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("pre_flush_idx", 256'(tile_idx_o), 256'(3));
      flush_i = 1'b1;
      tile_ready_i = 1'b0;
      tick();
      flush_i = 1'b0;
      grp_valid_i = 1'b0;
      cur_g++;
      tick();
      chk("flush_valid", 256'(tile_valid_o), 256'(0));
      chk("flush_ready", 256'(grp_ready_o), 256'(1));
      run(1, 1'b0);
      drive_grp(cur_g);
      tile_ready_i = 1'b1;
      tick();
      cur_g++;
      grp_valid_i = 1'b0;
      for (int k = 0; k < 20 && !(q.size() > 0 && q[0].idx == 5); k++) tick();
      chk("pre_reset_idx", 256'(tile_idx_o), 256'(5));
      #2 rstn = 1'b0;
      #1;
      reset_chk("async_rst");
      q.delete();
      done_pend = 1'b0;
      stall_prev = 1'b0;
      cnt_exp = '0;
      vrun = 0;
      tile_ready_i = 1'b0;
      @(negedge clk) rstn = 1'b1;
      @(posedge clk);
      #1;
      run(1, 1'b0);
      force dut.grp_cnt = 16'hFFFF;
      #1;
      release dut.grp_cnt;
      cnt_exp = 16'hFFFF;
      run(1, 1'b0);
      chk("cnt_wrap", 256'(grp_cnt_o), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
